// File: rtl/peridot_spim_pkg.sv
// Shared register map, bit positions and engine states
// for the Peridot SPI master with TX/RX FIFOs.
package peridot_spim_pkg;

  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_CTRL = 2'd1;
  localparam logic [1:0] REG_CONF = 2'd2;

  localparam int B_RXVALID = 15;

  localparam int B_IRQENA  = 15;
  localparam int B_RXOVR   = 14;
  localparam int B_TXOVR   = 13;
  localparam int B_TXEMPTY = 12;
  localparam int B_TXFULL  = 11;
  localparam int B_RXFULL  = 10;
  localparam int B_BUSY    = 9;

  localparam int B_BITRVS  = 15;
  localparam int B_MODE    = 12;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ENTRY = 3'd2,
    ST_SDI   = 3'd3,
    ST_SDO   = 3'd4,
    ST_DONE  = 3'd5
  } spim_state_t;

  function automatic logic [7:0] bit_rev8(input logic [7:0] d);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = d[7-i];
    return r;
  endfunction

endpackage

// File: rtl/peridot_spim_fifo.sv
// Synchronous FIFO with full/empty flags; a push while full
// is accepted only when a pop happens in the same cycle.
module peridot_spim_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/peridot_csr_spim_fifo.sv
// Avalon-MM SPI master: CSR block, TX/RX byte FIFOs and
// an MSB-first shift engine with programmable mode/divider.
module peridot_csr_spim_fifo
  import peridot_spim_pkg::*;
#(
  parameter int FIFO_DEPTH         = 16,
  parameter int SS_NUM             = 1,
  parameter int DEFAULT_REG_BITRVS = 0,
  parameter int DEFAULT_REG_MODE   = 0,
  parameter int DEFAULT_REG_CLKDIV = 255
) (
  input  logic              csi_clk,
  input  logic              rsi_reset_n,
  input  logic [1:0]        avs_address,
  input  logic              avs_read,
  output logic [31:0]       avs_readdata,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic              ins_irq,
  output logic [SS_NUM-1:0] spi_ss_n,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam logic [1:0] RST_MODE = 2'(DEFAULT_REG_MODE);
  localparam logic [7:0] RST_DIV  = 8'(DEFAULT_REG_CLKDIV);
  localparam logic       RST_RVS  = (DEFAULT_REG_BITRVS != 0);

  spim_state_t state, state_nx;

  logic              irqena, rxovr, txovr;
  logic [SS_NUM-1:0] sel;
  logic              bitrvs;
  logic [1:0]        mode;
  logic [7:0]        clkdiv;

  logic [7:0] divcnt;
  logic [3:0] bitcnt;
  logic [7:0] tx_sh;
  logic [7:0] rx_sh;
  logic       sclk;

  logic       wr_data, wr_ctrl, wr_conf, rd_data;
  logic       busy, phase_end;
  logic       tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0] tx_wdata, tx_rdata;
  logic       rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0] rx_rdata;
  logic       unused_wd;

  assign unused_wd = ^{avs_writedata[31:16], avs_writedata[11:8]};

  assign wr_data = avs_write & (avs_address == REG_DATA);
  assign wr_ctrl = avs_write & (avs_address == REG_CTRL);
  assign wr_conf = avs_write & (avs_address == REG_CONF);
  assign rd_data = avs_read  & (avs_address == REG_DATA);

  assign busy      = (state != ST_IDLE);
  assign phase_end = (divcnt == '0);

  // Bit order is fixed up at the FIFO boundary so the shifter is MSB-first.
  assign tx_push  = wr_data;
  assign tx_wdata = bitrvs ? bit_rev8(avs_writedata[7:0])
                           : avs_writedata[7:0];
  assign tx_pop   = (state == ST_LOAD);
  assign rx_push  = (state == ST_DONE) & phase_end;
  assign rx_pop   = rd_data & ~rx_empty;

  peridot_spim_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(8)
  ) u_txf (
    .clk   (csi_clk),
    .rst_n (rsi_reset_n),
    .push  (tx_push),
    .wdata (tx_wdata),
    .pop   (tx_pop),
    .rdata (tx_rdata),
    .full  (tx_full),
    .empty (tx_empty)
  );

  peridot_spim_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(8)
  ) u_rxf (
    .clk   (csi_clk),
    .rst_n (rsi_reset_n),
    .push  (rx_push),
    .wdata (rx_sh),
    .pop   (rx_pop),
    .rdata (rx_rdata),
    .full  (rx_full),
    .empty (rx_empty)
  );

  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      irqena <= 1'b0;
      rxovr  <= 1'b0;
      txovr  <= 1'b0;
      sel    <= '0;
      bitrvs <= RST_RVS;
      mode   <= RST_MODE;
      clkdiv <= RST_DIV;
    end else begin
      if (wr_ctrl) begin
        irqena <= avs_writedata[B_IRQENA];
        sel    <= avs_writedata[SS_NUM-1:0];
      end
      if (wr_ctrl && avs_writedata[B_RXOVR]) rxovr <= 1'b0;
      if (wr_ctrl && avs_writedata[B_TXOVR]) txovr <= 1'b0;
      if (rx_push && rx_full && !rx_pop) rxovr <= 1'b1;
      if (tx_push && tx_full && !tx_pop) txovr <= 1'b1;
      if (wr_conf && !busy && tx_empty) begin
        bitrvs <= avs_writedata[B_BITRVS];
        mode   <= avs_writedata[B_MODE+:2];
        clkdiv <= avs_writedata[7:0];
      end
    end
  end

  always_comb begin
    avs_readdata = '0;
    unique case (avs_address)
      REG_DATA: begin
        avs_readdata[B_RXVALID] = ~rx_empty;
        if (!rx_empty)
          avs_readdata[7:0] = bitrvs ? bit_rev8(rx_rdata) : rx_rdata;
      end
      REG_CTRL: begin
        avs_readdata[B_IRQENA]   = irqena;
        avs_readdata[B_RXOVR]    = rxovr;
        avs_readdata[B_TXOVR]    = txovr;
        avs_readdata[B_TXEMPTY]  = tx_empty;
        avs_readdata[B_TXFULL]   = tx_full;
        avs_readdata[B_RXFULL]   = rx_full;
        avs_readdata[B_BUSY]     = busy;
        avs_readdata[SS_NUM-1:0] = sel;
      end
      REG_CONF: begin
        avs_readdata[B_BITRVS]   = bitrvs;
        avs_readdata[B_MODE+:2]  = mode;
        avs_readdata[7:0]        = clkdiv;
      end
      default: avs_readdata = '0;
    endcase
  end

  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) state <= ST_IDLE;
    else              state <= state_nx;
  end

  // CPHA=1 spends its first half-bit in ENTRY, so it finishes on an SDI.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (!tx_empty) state_nx = ST_LOAD;
      ST_LOAD:  state_nx = mode[0] ? ST_ENTRY : ST_SDI;
      ST_ENTRY: if (phase_end) state_nx = ST_SDI;
      ST_SDI:
        if (phase_end)
          state_nx = (mode[0] && bitcnt == 4'd7) ? ST_DONE : ST_SDO;
      ST_SDO:
        if (phase_end)
          state_nx = (!mode[0] && bitcnt == 4'd8) ? ST_DONE : ST_SDI;
      ST_DONE:
        if (phase_end)
          state_nx = tx_empty ? ST_IDLE : ST_LOAD;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      divcnt <= '0;
      bitcnt <= '0;
      tx_sh  <= '0;
      rx_sh  <= '0;
      sclk   <= RST_MODE[1];
    end else begin
      if (state == ST_LOAD) begin
        divcnt <= clkdiv;
        bitcnt <= '0;
        tx_sh  <= tx_rdata;
        sclk   <= mode[1];
      end else if (busy) begin
        divcnt <= phase_end ? clkdiv : divcnt - 1'b1;
      end
      if (phase_end && (state inside {ST_ENTRY, ST_SDI, ST_SDO}))
        sclk <= ~sclk;
      if (phase_end && state == ST_SDI) begin
        rx_sh  <= {rx_sh[6:0], spi_miso};
        bitcnt <= bitcnt + 1'b1;
      end
      if (phase_end && state == ST_SDO)
        tx_sh <= {tx_sh[6:0], 1'b0};
    end
  end

  assign spi_ss_n = ~sel;
  assign spi_sclk = sclk;
  assign spi_mosi = tx_sh[7];
  assign ins_irq  = irqena & tx_empty & ~busy;

endmodule

// File: tb/tb_peridot_csr_spim_fifo.sv
// Self-checking bench for peridot_csr_spim_fifo: loopback
// transfers checked against a byte-level reference model.
module tb_peridot_csr_spim_fifo;

  localparam int DEPTH = 4;
  localparam int SSN   = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [1:0]     avs_address = '0;
  logic           avs_read = 1'b0;
  logic [31:0]    avs_readdata;
  logic           avs_write = 1'b0;
  logic [31:0]    avs_writedata = '0;
  logic           ins_irq;
  logic [SSN-1:0] spi_ss_n;
  logic           spi_sclk;
  logic           spi_mosi;
  logic           spi_miso;
  logic           miso_inv = 1'b0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rises = 0;
  logic [7:0] cap_r = '0;
  logic [7:0] cap_f = '0;

  always #5 clk = ~clk;

  assign spi_miso = spi_mosi ^ miso_inv;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge spi_sclk) begin
    rises <= rises + 1;
    cap_r <= {cap_r[6:0], spi_mosi};
  end

  always @(negedge spi_sclk) cap_f <= {cap_f[6:0], spi_mosi};

  peridot_csr_spim_fifo #(
    .FIFO_DEPTH(DEPTH),
    .SS_NUM(SSN)
  ) dut (
    .csi_clk       (clk),
    .rsi_reset_n   (rst_n),
    .avs_address   (avs_address),
    .avs_read      (avs_read),
    .avs_readdata  (avs_readdata),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .ins_irq       (ins_irq),
    .spi_ss_n      (spi_ss_n),
    .spi_sclk      (spi_sclk),
    .spi_mosi      (spi_mosi),
    .spi_miso      (spi_miso)
  );

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  // Cycles from the first push until the engine is idle again.
  function automatic int xfer_cycles(input int n, input int d);
    return 1 + n * (1 + 17 * (d + 1));
  endfunction

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    @(negedge clk);
    avs_write     = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
    avs_address = a;
    avs_read    = 1'b1;
    #1;
    d = avs_readdata;
    @(negedge clk);
    avs_read    = 1'b0;
  endtask

  task automatic wait_irq(input int limit, output bit to);
    int n;
    n  = 0;
    to = 1'b1;
    while (n < limit) begin
      if (ins_irq === 1'b1) begin
        to = 1'b0;
        break;
      end
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    repeat (3) @(negedge clk);
    total++;
    if (spi_ss_n !== 2'b11 || spi_sclk !== 1'b0 || spi_mosi !== 1'b0 ||
        ins_irq !== 1'b0) begin
      bad++;
      $display("FAIL reset_pins: ss_n=%b sclk=%b mosi=%b irq=%b want 11 0 0 0",
               spi_ss_n, spi_sclk, spi_mosi, ins_irq);
    end
    rst_n = 1'b1;
    @(negedge clk);
    bus_rd(2'd1, d);
    total++;
    if (d !== 32'h0000_1000) begin
      bad++;
      $display("FAIL reset_reg1: got %h want 00001000", d);
    end
    bus_rd(2'd2, d);
    total++;
    if (d !== 32'h0000_00FF) begin
      bad++;
      $display("FAIL reset_reg2: got %h want 000000ff", d);
    end
    bus_rd(2'd0, d);
    total++;
    if (d !== 32'h0) begin
      bad++;
      $display("FAIL reset_reg0: got %h want 00000000", d);
    end
    bus_rd(2'd3, d);
    total++;
    if (d !== 32'h0) begin
      bad++;
      $display("FAIL reset_reg3: got %h want 00000000", d);
    end
  endtask

  task automatic test_select();
    logic [31:0] d;
    bus_wr(2'd1, 32'h0000_0001);
    total++;
    if (spi_ss_n !== 2'b10) begin
      bad++;
      $display("FAIL select1: got %b want 10", spi_ss_n);
    end
    bus_wr(2'd1, 32'h0000_0002);
    bus_rd(2'd1, d);
    total++;
    if (spi_ss_n !== 2'b01 || d !== 32'h0000_1002) begin
      bad++;
      $display("FAIL select2: ss_n=%b reg1=%h want 01 00001002", spi_ss_n, d);
    end
    bus_wr(2'd1, 32'h0);
  endtask

  task automatic test_mode0();
    logic [31:0] d;
    int r0, t0;
    bit to;
    miso_inv = 1'b0;
    bus_wr(2'd2, 32'h0000_0000);
    bus_wr(2'd1, 32'h0000_8000);
    total++;
    if (ins_irq !== 1'b1) begin
      bad++;
      $display("FAIL irq_idle: got %b want 1", ins_irq);
    end
    r0 = rises;
    bus_wr(2'd0, 32'h0000_00A5);
    t0 = cyc;
    wait_irq(500, to);
    total++;
    if (to || (cyc - t0) != xfer_cycles(1, 0)) begin
      bad++;
      $display("FAIL mode0_time: got %0d (timeout=%0d) want %0d",
               cyc - t0, to, xfer_cycles(1, 0));
    end
    total++;
    if (rises - r0 != 8) begin
      bad++;
      $display("FAIL mode0_edges: got %0d want 8", rises - r0);
    end
    bus_rd(2'd0, d);
    total++;
    if (d !== 32'h0000_80A5) begin
      bad++;
      $display("FAIL mode0_rx: got %h want 000080a5", d);
    end
    bus_rd(2'd1, d);
    total++;
    if (d !== 32'h0000_9000) begin
      bad++;
      $display("FAIL mode0_status: got %h want 00009000", d);
    end
    bus_rd(2'd0, d);
    total++;
    if (d[15] !== 1'b0) begin
      bad++;
      $display("FAIL mode0_empty: rxvalid got %b want 0", d[15]);
    end
  endtask

  task automatic test_mode3();
    logic [31:0] d;
    int t0;
    bit to;
    bus_wr(2'd2, 32'h0000_3003);
    bus_wr(2'd0, 32'h0000_003C);
    t0 = cyc;
    bus_wr(2'd0, 32'h0000_00C3);
    wait_irq(1000, to);
    total++;
    if (to || (cyc - t0) != xfer_cycles(2, 3)) begin
      bad++;
      $display("FAIL mode3_time: got %0d (timeout=%0d) want %0d",
               cyc - t0, to, xfer_cycles(2, 3));
    end
    total++;
    if (spi_sclk !== 1'b1) begin
      bad++;
      $display("FAIL mode3_idle_sclk: got %b want 1", spi_sclk);
    end
    bus_rd(2'd0, d);
    total++;
    if (d !== 32'h0000_803C) begin
      bad++;
      $display("FAIL mode3_rx0: got %h want 0000803c", d);
    end
    bus_rd(2'd0, d);
    total++;
    if (d !== 32'h0000_80C3) begin
      bad++;
      $display("FAIL mode3_rx1: got %h want 000080c3", d);
    end
  endtask

  task automatic test_bitrvs();
    logic [31:0] d;
    bit to;
    bus_wr(2'd2, 32'h0000_8000);
    bus_wr(2'd0, 32'h0000_0001);
    wait_irq(500, to);
    total++;
    if (to || cap_r !== 8'h80) begin
      bad++;
      $display("FAIL bitrvs_wire: got %h (timeout=%0d) want 80", cap_r, to);
    end
    bus_rd(2'd0, d);
    total++;
    if (d !== 32'h0000_8001) begin
      bad++;
      $display("FAIL bitrvs_rx: got %h want 00008001", d);
    end
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [7:0]  q[$];
    logic [7:0]  b, wire_exp, wire_got;
    int m, dv, rvs, n, t0;
    bit to;
    for (int k = 0; k < 8; k++) begin
      m   = $urandom_range(0, 3);
      dv  = $urandom_range(0, 3);
      rvs = $urandom_range(0, 1);
      n   = $urandom_range(1, 3);
      miso_inv = 1'($urandom_range(0, 1));
      d = (32'(rvs) << 15) | (32'(m) << 12) | 32'(dv);
      bus_wr(2'd2, d);
      bus_rd(2'd2, avs_writedata);
      total++;
      if (avs_writedata !== d) begin
        bad++;
        $display("FAIL rnd_conf: got %h want %h", avs_writedata, d);
      end
      q.delete();
      t0 = 0;
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        q.push_back(b);
        bus_wr(2'd0, {24'h0, b});
        if (i == 0) t0 = cyc;
      end
      wait_irq(xfer_cycles(n, dv) + 50, to);
      total++;
      if (to || (cyc - t0) != xfer_cycles(n, dv)) begin
        bad++;
        $display("FAIL rnd_time: got %0d (timeout=%0d) want %0d",
                 cyc - t0, to, xfer_cycles(n, dv));
      end
      wire_exp = rvs ? rev8(q[n-1]) : q[n-1];
      wire_got = (m == 0 || m == 3) ? cap_r : cap_f;
      total++;
      if (wire_got !== wire_exp) begin
        bad++;
        $display("FAIL rnd_wire: mode %0d got %h want %h", m, wire_got, wire_exp);
      end
      for (int i = 0; i < n; i++) begin
        bus_rd(2'd0, d);
        total++;
        if (d !== (32'h8000 | {24'h0, q[i] ^ {8{miso_inv}}})) begin
          bad++;
          $display("FAIL rnd_rx: byte %0d got %h want %h", i, d,
                   32'h8000 | {24'h0, q[i] ^ {8{miso_inv}}});
        end
      end
    end
    miso_inv = 1'b0;
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    logic [7:0]  q[$];
    logic [7:0]  b;
    int t0;
    bit to;
    bus_wr(2'd2, 32'h0000_00FF);
    bus_wr(2'd1, 32'h0000_8000);
    t0 = 0;
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      q.push_back(b);
      bus_wr(2'd0, {24'h0, b});
      if (i == 0) t0 = cyc;
    end
    bus_rd(2'd1, d);
    total++;
    if (d !== 32'h0000_AA00) begin
      bad++;
      $display("FAIL ovf_tx_status: got %h want 0000aa00", d);
    end
    bus_wr(2'd2, 32'h0000_3001);
    bus_rd(2'd2, d);
    total++;
    if (d !== 32'h0000_00FF) begin
      bad++;
      $display("FAIL conf_busy_ignored: got %h want 000000ff", d);
    end
    wait_irq(xfer_cycles(5, 255) + 100, to);
    total++;
    if (to || (cyc - t0) != xfer_cycles(5, 255)) begin
      bad++;
      $display("FAIL ovf_time: got %0d (timeout=%0d) want %0d",
               cyc - t0, to, xfer_cycles(5, 255));
    end
    bus_rd(2'd1, d);
    total++;
    if (d !== 32'h0000_F400) begin
      bad++;
      $display("FAIL ovf_rx_status: got %h want 0000f400", d);
    end
    bus_wr(2'd1, 32'h0000_E000);
    bus_rd(2'd1, d);
    total++;
    if (d !== 32'h0000_9400) begin
      bad++;
      $display("FAIL ovf_w1c: got %h want 00009400", d);
    end
    for (int i = 0; i < DEPTH; i++) begin
      bus_rd(2'd0, d);
      total++;
      if (d !== (32'h8000 | {24'h0, q[i]})) begin
        bad++;
        $display("FAIL ovf_rx: byte %0d got %h want %h", i, d,
                 32'h8000 | {24'h0, q[i]});
      end
    end
    bus_rd(2'd0, d);
    total++;
    if (d[15] !== 1'b0) begin
      bad++;
      $display("FAIL ovf_drained: rxvalid got %b want 0", d[15]);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    int r0;
    bus_wr(2'd2, 32'h0000_0007);
    bus_wr(2'd1, 32'h0000_8003);
    bus_wr(2'd0, 32'h0000_00FF);
    repeat (45) @(negedge clk);
    total++;
    if (spi_ss_n !== 2'b00 || ins_irq !== 1'b0) begin
      bad++;
      $display("FAIL mid_busy: ss_n=%b irq=%b want 00 0", spi_ss_n, ins_irq);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (spi_ss_n !== 2'b11 || spi_sclk !== 1'b0 || spi_mosi !== 1'b0 ||
        ins_irq !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_pins: ss_n=%b sclk=%b mosi=%b irq=%b want 11 0 0 0",
               spi_ss_n, spi_sclk, spi_mosi, ins_irq);
    end
    @(negedge clk);
    rst_n = 1'b1;
    r0 = rises;
    repeat (20) @(negedge clk);
    total++;
    if (rises != r0) begin
      bad++;
      $display("FAIL mid_aborted: sclk rises got %0d want 0", rises - r0);
    end
    bus_rd(2'd0, d);
    total++;
    if (d !== 32'h0) begin
      bad++;
      $display("FAIL mid_rx_discard: got %h want 00000000", d);
    end
    bus_rd(2'd1, d);
    total++;
    if (d !== 32'h0000_1000) begin
      bad++;
      $display("FAIL mid_reg1: got %h want 00001000", d);
    end
    bus_rd(2'd2, d);
    total++;
    if (d !== 32'h0000_00FF) begin
      bad++;
      $display("FAIL mid_reg2: got %h want 000000ff", d);
    end
  endtask

  initial begin
    test_reset();
    test_select();
    test_mode0();
    test_mode3();
    test_bitrvs();
    test_random();
    test_overflow();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/peridot_csr_spim_fifo.md
PERIDOT_CSR_SPIM_FIFO -- requirements
Module: peridot_csr_spim_fifo

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, meaning entries per TX and per RX FIFO (power of 2, 2-256).
REQ-002 SHALL have parameter SS_NUM, default 1, meaning number of chip-select outputs (1-8).
REQ-003 SHALL have parameter DEFAULT_REG_BITRVS, default 0, meaning reset LSB-first flag.
REQ-004 SHALL have parameter DEFAULT_REG_MODE, default 0, meaning reset SPI mode (0-3).
REQ-005 SHALL have parameter DEFAULT_REG_CLKDIV, default 255, meaning reset divider; bit rate = clk/((clkdiv+1)*2).
REQ-006 SHALL have port csi_clk  in  1  sole clock, all logic rising-edge.
REQ-007 SHALL have port rsi_reset_n  in  1  asynchronous active-low reset.
REQ-008 SHALL have ports avs_address in 2, avs_read in 1, avs_readdata out 32, avs_write in 1, avs_writedata in 32: Avalon-MM slave, zero wait states, single-cycle read/write strobes.
REQ-009 SHALL have port ins_irq  out  1  level interrupt.
REQ-010 SHALL have ports spi_ss_n out SS_NUM (active-low selects), spi_sclk out 1, spi_mosi out 1, spi_miso in 1.

Function
REQ-011 SHALL map reg0 (+0): write bit7-0 pushes TX byte; read returns bit15 rxvalid, bit7-0 RX head, and a read with rxvalid=1 pops RX FIFO.
REQ-012 SHALL map reg1 (+4): bit15 irqena RW, bit14 rxovr R/W1C, bit13 txovr R/W1C, bit12 txempty R, bit11 txfull R, bit10 rxfull R, bit9 busy R, bit(SS_NUM-1)-0 select RW.
REQ-013 SHALL map reg2 (+8): bit15 bitrvs RW, bit13-12 mode RW, bit7-0 clkdiv RW; reg3 reads 0; unused bits read 0.
REQ-014 SHALL accept reg2 writes only when busy=0 and TX FIFO empty; otherwise the write is ignored.
REQ-015 SHALL apply bitrvs at TX push and at RX read (bit-reverse the byte), so the shifter is always MSB-first.
REQ-016 SHALL drive spi_ss_n[i] = ~select[i] at all times; select writes are accepted anytime, including mid-byte.
REQ-017 SHALL run engine states IDLE, LOAD, ENTRY, SDI, SDO, DONE; busy=1 in every state except IDLE.
REQ-018 SHALL go IDLE->LOAD when TX FIFO non-empty; LOAD (1 cycle) pops TX, loads shifter, sets sclk=mode[1], loads divcount=clkdiv.
REQ-019 SHALL go LOAD->SDI for mode 0/2 and LOAD->ENTRY for mode 1/3; every ENTRY/SDI/SDO/DONE phase lasts clkdiv+1 cycles and toggles sclk at its end (DONE excepted).
REQ-020 SHALL sample spi_miso into rx shifter at end of SDI, shift tx left at end of SDO, spi_mosi = tx shifter bit7.
REQ-021 SHALL complete after 8 bits: mode 0/2 ends after 8th SDO, mode 1/3 after 8th SDI; then DONE, then push RX byte and return to LOAD if TX non-empty, else IDLE.
REQ-022 SHALL take exactly 1+17*(clkdiv+1) cycles per byte from LOAD entry to RX push; back-to-back bytes have no extra gap.
REQ-023 SHALL on TX push with TX full drop the byte and set txovr; on RX push with RX full and no simultaneous pop drop the byte and set rxovr.
REQ-024 SHALL allow simultaneous push and pop on either FIFO in one cycle, including at full (push accepted) and empty-TX-with-engine-pop (not possible: pop requires non-empty).
REQ-025 SHALL drive ins_irq = irqena & txempty & ~busy.

Reset
REQ-026 SHALL on rsi_reset_n=0 asynchronously: engine IDLE, both FIFOs empty, select=0 (spi_ss_n all 1), sclk=DEFAULT_REG_MODE[1], mosi=0, irqena=0, rxovr=txovr=0, bitrvs/mode/clkdiv=parameter defaults, ins_irq=0.
REQ-027 SHALL on reset mid-byte abort the transfer and discard partial RX data.

Structure
REQ-028 SHALL place register offsets, bit positions and engine state encodings in shared package peridot_spim_pkg.
REQ-029 SHALL instantiate sub-module peridot_spim_fifo (sync FIFO, width 8, depth FIFO_DEPTH, full/empty flags) twice, TX and RX.

Verification
REQ-030 Mode 0, clkdiv=0, push 0xA5 with miso looped to mosi -> 8 sclk rising edges, RX=0xA5 after 18 cycles, busy then 0, irq=1 if irqena.
REQ-031 Mode 3, clkdiv=3, push 0x3C,0xC3 -> sclk idles 1, 138 cycles total, RX FIFO holds 0x3C,0xC3 in order.
REQ-032 bitrvs=1, push 0x01, loopback -> mosi first bit 1 then seven 0s; reg0 reads 0x8001.
REQ-033 FIFO_DEPTH=4, 6 pushes while engine stalled by clkdiv=255 -> txfull=1, txovr=1, only 5 bytes transmitted (1 in shifter + 4 queued).
REQ-034 RX full (4 bytes unread), 5th byte completes -> rxovr=1, FIFO contents unchanged; W1C clears rxovr.
REQ-035 Reset asserted mid-SDO -> all outputs to REQ-026 values immediately; reg2 write during busy -> ignored, readback unchanged.
